// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional feature macro used by fetch_unit: FETCH_MISALIGN_TRAP_EN.
package riscv_fetch_pkg;

  // Byte address of the first fetch after reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Instruction memory depth in words. The memory decodes only the low
  // index bits, so the full word index on imem_addr wraps naturally.
  localparam int IMEM_WORDS = 64;

  localparam int FETCH_BUF_DEPTH = 2;

  // Wide enough to hold 0..FETCH_BUF_DEPTH.
  localparam int CNT_W = 2;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    TRAPPED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry instruction buffer between the memory return and decode.
// Entry 0 is always the head, so the presented instruction comes straight
// from a register. Flush empties the buffer but leaves entry contents alone.
module fetch_buffer
  import riscv_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             enq,
  input  fetch_entry_t     enq_entry,
  input  logic             deq,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(FETCH_BUF_DEPTH);

  fetch_entry_t     entry0_q;
  fetch_entry_t     entry1_q;
  logic [CNT_W-1:0] count_q;

  // Entry storage and occupancy; a dequeue shifts entry 1 into the head.
  always_ff @(posedge clk) begin
    if (!reset) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      case ({enq, deq})
        2'b10: begin
          if (count_q == '0) entry0_q <= enq_entry;
          else               entry1_q <= enq_entry;
          count_q <= count_q + CNT_W'(1);
        end
        2'b01: begin
          if (count_q == FULL) entry0_q <= entry1_q;
          count_q <= count_q - CNT_W'(1);
        end
        2'b11: begin
          if (count_q == FULL) begin
            entry0_q <= entry1_q;
            entry1_q <= enq_entry;
          end else begin
            entry0_q <= enq_entry;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = entry0_q;
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word reads to a one-cycle
// instruction memory, buffers returns and hands them to decode.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirect targets trap
// instead of being silently aligned.
//
//   state   | meaning
//   RUN     | fetching normally
//   TRAPPED | misaligned redirect seen, waiting for an aligned redirect
module fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  output logic        fetch_misaligned,
  output logic [31:0] fetch_bad_addr
);

  localparam logic [CNT_W:0] DEPTH = (CNT_W + 1)'(FETCH_BUF_DEPTH);

  fetch_state_t     state_q;
  fetch_state_t     state_d;
  logic [31:0]      pc_q;
  logic [31:0]      req_pc_q;
  logic             req_valid_q;
  logic [31:0]      target_pc;
  logic             bad_target;
  logic             deq;
  logic             enq;
  logic             issue;
  logic [CNT_W:0]   occupancy;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head;
  fetch_entry_t     enq_entry;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign bad_target = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign target_pc  = redirect_pc;
`else
  assign bad_target = 1'b0;
  assign target_pc  = redirect_pc & 32'hFFFF_FFFC;
`endif

  assign deq = if_valid && id_ready;
  // A redirect discards whatever the memory is returning this cycle.
  assign enq = req_valid_q && !redirect_valid;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next state: every redirect decides between running and trapping.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) state_d = bad_target ? TRAPPED : RUN;
  end

  // Issue decision: only when the request plus buffered entries still fit.
  always_comb begin
    occupancy = {1'b0, count} + {{CNT_W{1'b0}}, req_valid_q};
    issue     = 1'b0;
    if (state_q == RUN && !redirect_valid &&
        (occupancy - {{CNT_W{1'b0}}, deq}) < DEPTH)
      issue = 1'b1;
  end

  // PC and in-flight request tracking.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      req_pc_q    <= '0;
    end else if (redirect_valid) begin
      pc_q        <= target_pc;
      req_valid_q <= 1'b0;
    end else begin
      req_valid_q <= issue;
      if (issue) begin
        req_pc_q <= pc_q;
        pc_q     <= pc_q + 32'd4;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Trap pulse and the offending target, refreshed on every redirect.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_misaligned <= 1'b0;
      fetch_bad_addr   <= '0;
    end else begin
      fetch_misaligned <= bad_target;
      if (redirect_valid) fetch_bad_addr <= bad_target ? redirect_pc : 32'h0;
    end
  end
`else
  assign fetch_misaligned = 1'b0;
  assign fetch_bad_addr   = '0;
`endif

  assign imem_addr = {2'b00, pc_q[31:2]};

  always_comb begin
    enq_entry       = '0;
    enq_entry.instr = imem_instr;
    enq_entry.pc    = req_pc_q;
  end

  fetch_buffer u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .enq       (enq),
    .enq_entry (enq_entry),
    .deq       (deq),
    .head      (head),
    .count     (count)
  );

  assign if_valid = (count != '0);
  assign if_instr = head.instr;
  assign if_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of per-cycle vectors followed by a
// hand-written stall/release sequence with in-order delivery checking.
module tb_fetch_unit;
  import riscv_fetch_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        fetch_misaligned;
  logic [31:0] fetch_bad_addr;

  logic [31:0] mem [IMEM_WORDS];

  int n_vec = 0;
  int n_err = 0;

  fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .imem_addr        (imem_addr),
    .imem_instr       (imem_instr),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .if_valid         (if_valid),
    .if_instr         (if_instr),
    .if_pc            (if_pc),
    .id_ready         (id_ready),
    .fetch_misaligned (fetch_misaligned),
    .fetch_bad_addr   (fetch_bad_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle registered read; only the low index bits are decoded.
  always @(posedge clk) imem_instr <= mem[imem_addr[5:0]];

  // Word i holds addi-like encoding with i in both imm and rd fields.
  function automatic logic [31:0] word_of(input logic [31:0] byte_pc);
    logic [5:0] w;
    w = byte_pc[7:2];
    return {6'b0, w, 20'h0} | ({27'b0, w[4:0]} << 7) | 32'h0000_0013;
  endfunction

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_addr;
    logic        e_mis;
    logic [31:0] e_bad;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic rdy, input logic rv,
                              input logic [31:0] rpc, input logic ev,
                              input logic [31:0] epc, input logic [31:0] eaddr);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.e_valid = ev; v.e_pc = epc; v.e_addr = eaddr;
    v.e_mis = 1'b0; v.e_bad = 32'h0;
    return v;
  endfunction

  function automatic vec_t mkt(input vec_t b, input logic mis, input logic [31:0] bad);
    vec_t v;
    v = b;
    v.e_mis = mis;
    v.e_bad = bad;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    int got;
    reset          = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    for (int i = 0; i < IMEM_WORDS; i++) mem[i] = word_of(32'(i) * 4);

    // Reset release, full-rate streaming
    vecs.push_back(mk(0,1,0,32'h0,            0,32'h0,        32'd0));
    vecs.push_back(mk(1,1,0,32'h0,            0,32'h0,        32'd1));
    vecs.push_back(mk(1,1,0,32'h0,            1,32'h0,        32'd2));
    vecs.push_back(mk(1,1,0,32'h0,            1,32'h4,        32'd3));
    vecs.push_back(mk(1,1,0,32'h0,            1,32'h8,        32'd4));
    vecs.push_back(mk(1,1,0,32'h0,            1,32'hC,        32'd5));
    // Stall with buffer full, then release
    vecs.push_back(mk(0,1,0,32'h0,            0,32'h0,        32'd0));
    vecs.push_back(mk(1,1,0,32'h0,            0,32'h0,        32'd1));
    vecs.push_back(mk(1,0,0,32'h0,            1,32'h0,        32'd2));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1,0,0,32'h0,          1,32'h0,        32'd2));
    vecs.push_back(mk(1,1,0,32'h0,            1,32'h4,        32'd3));
    vecs.push_back(mk(1,1,0,32'h0,            1,32'h8,        32'd4));
    // Redirect while 0x8 presented and 0xC in flight
    vecs.push_back(mk(1,1,1,32'h20,           0,32'h0,        32'd8));
    vecs.push_back(mk(1,1,0,32'h0,            0,32'h0,        32'd9));
    vecs.push_back(mk(1,1,0,32'h0,            1,32'h20,       32'd10));
    vecs.push_back(mk(1,1,0,32'h0,            1,32'h24,       32'd11));
    // Fill buffer, then redirect with same-cycle dequeue
    vecs.push_back(mk(1,0,0,32'h0,            1,32'h24,       32'd11));
    vecs.push_back(mk(1,1,1,32'h40,           0,32'h0,        32'd16));
    vecs.push_back(mk(1,1,0,32'h0,            0,32'h0,        32'd17));
    vecs.push_back(mk(1,1,0,32'h0,            1,32'h40,       32'd18));
    vecs.push_back(mk(1,1,0,32'h0,            1,32'h44,       32'd19));
    // Mid-stream reset
    vecs.push_back(mk(0,1,0,32'h0,            0,32'h0,        32'd0));
    vecs.push_back(mk(1,1,0,32'h0,            0,32'h0,        32'd1));
    vecs.push_back(mk(1,1,0,32'h0,            1,32'h0,        32'd2));
    vecs.push_back(mk(1,1,0,32'h0,            1,32'h4,        32'd3));
    // Misaligned redirect target 0x22, then redirect to 0x40
`ifdef FETCH_MISALIGN_TRAP_EN
    vecs.push_back(mkt(mk(1,1,1,32'h22,       0,32'h0,        32'd8), 1, 32'h22));
    vecs.push_back(mkt(mk(1,1,0,32'h0,        0,32'h0,        32'd8), 0, 32'h22));
    vecs.push_back(mkt(mk(1,1,0,32'h0,        0,32'h0,        32'd8), 0, 32'h22));
`else
    vecs.push_back(mk(1,1,1,32'h22,           0,32'h0,        32'd8));
    vecs.push_back(mk(1,1,0,32'h0,            0,32'h0,        32'd9));
    vecs.push_back(mk(1,1,0,32'h0,            1,32'h20,       32'd10));
`endif
    vecs.push_back(mk(1,1,1,32'h40,           0,32'h0,        32'd16));
    vecs.push_back(mk(1,1,0,32'h0,            0,32'h0,        32'd17));
    vecs.push_back(mk(1,1,0,32'h0,            1,32'h40,       32'd18));
    // PC wraps at 2^32, memory index wraps at IMEM_WORDS
    vecs.push_back(mk(1,1,1,32'hFFFF_FFFC,    0,32'h0,        32'h3FFF_FFFF));
    vecs.push_back(mk(1,1,0,32'h0,            0,32'h0,        32'd0));
    vecs.push_back(mk(1,1,0,32'h0,            1,32'hFFFF_FFFC,32'd1));
    vecs.push_back(mk(1,1,0,32'h0,            1,32'h0,        32'd2));

    repeat (3) @(posedge clk);
    #1;
    chk("rst if_valid", {31'b0, if_valid}, 32'h0);
    chk("rst if_pc", if_pc, 32'h0);
    chk("rst if_instr", if_instr, 32'h0);
    chk("rst imem_addr", imem_addr, RESET_PC_DEFAULT >> 2);
    chk("rst misaligned", {31'b0, fetch_misaligned}, 32'h0);
    chk("rst bad_addr", fetch_bad_addr, 32'h0);

    for (int k = 0; k < vecs.size(); k++) begin
      reset          = vecs[k].rst;
      id_ready       = vecs[k].rdy;
      redirect_valid = vecs[k].rv;
      redirect_pc    = vecs[k].rpc;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d if_valid", k), {31'b0, if_valid}, {31'b0, vecs[k].e_valid});
      chk($sformatf("v%0d imem_addr", k), imem_addr, vecs[k].e_addr);
      chk($sformatf("v%0d misaligned", k), {31'b0, fetch_misaligned}, {31'b0, vecs[k].e_mis});
      chk($sformatf("v%0d bad_addr", k), fetch_bad_addr, vecs[k].e_bad);
      if (vecs[k].e_valid) begin
        chk($sformatf("v%0d if_pc", k), if_pc, vecs[k].e_pc);
        chk($sformatf("v%0d if_instr", k), if_instr, word_of(vecs[k].e_pc));
      end else if (!vecs[k].rst) begin
        chk($sformatf("v%0d rst if_pc", k), if_pc, 32'h0);
        chk($sformatf("v%0d rst if_instr", k), if_instr, 32'h0);
      end
    end
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Hand sequence: hold decode off after reset, then drain with a
    // stuttering ready and check strict in-order, gap-free delivery.
    reset    = 1'b0;
    id_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 10 && !if_valid; i++) begin
      @(posedge clk);
      #1;
    end
    chk("hs first valid", {31'b0, if_valid}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hs stall%0d imem_addr", i), imem_addr, 32'd2);
      chk($sformatf("hs stall%0d if_pc", i), if_pc, 32'h0);
    end
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      id_ready = (cyc % 3) != 2;
      if (if_valid && id_ready) begin
        chk($sformatf("hs deliver%0d pc", got), if_pc, 32'(got) * 4);
        chk($sformatf("hs deliver%0d instr", got), if_instr, word_of(32'(got) * 4));
        got++;
      end
      @(posedge clk);
      #1;
    end
    chk("hs delivered count", 32'(got), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
